// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: parity modes, TX FSM states
// and the smallest frame width the line side will ever send.
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Host-side word stream into the transmitter FIFO.
// A word transfers on every clk edge where in_valid && in_ready; in_data must be
// stable while in_valid is high, and in_ready depends only on FIFO occupancy.
interface uart_tx_buffered_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; full and empty come
// from an occupancy counter so the pointers may wrap freely.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed, runtime frame format, back-to-back
// frames and line break, with all line-side state paced by baud_tick.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_tick,
  uart_tx_buffered_if.slave             in_if,
  input  logic [$clog2(DATA_BITS+1)-1:0] cfg_data_len,
  input  logic [2:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          break_req,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_empty,
  output tx_state_e                     dbg_state
);
  localparam int LW = $clog2(DATA_BITS+1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [LW-1:0]        idx_q, idx_d, len_q, len_d;
  logic                 has_par_q, has_par_d, par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
  logic                 pin_q, pin_d, done_q, done_d;
  logic                 fifo_full, fifo_pop, pick;
  logic [DATA_BITS-1:0] fifo_data;
  logic [LW-1:0]        cfg_len;
  parity_e              cfg_par;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len < LW'(MIN_DATA_BITS)) return LW'(MIN_DATA_BITS);
    if (len > LW'(DATA_BITS))     return LW'(DATA_BITS);
    return len;
  endfunction

  function automatic parity_e decode_parity(input logic [2:0] code);
    if (code > 3'd4) return PAR_NONE;
    return parity_e'(code);
  endfunction

  // Parity covers only the bits that will actually be sent.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                      input logic [LW-1:0] len,
                                      input parity_e par);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i < int'(len)) x = x ^ d[i];
    end
    case (par)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (in_if.in_valid),
    .push_data_i (in_if.in_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_data),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign in_if.in_ready = !fifo_full;
  assign cfg_len        = clamp_len(cfg_data_len);
  assign cfg_par        = decode_parity(cfg_parity);
  assign tx_pin         = pin_q;
  assign tx_busy        = (state_q != ST_IDLE);
  assign tx_done        = done_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    len_d      = len_q;
    has_par_d  = has_par_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    pin_d      = pin_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    pick       = 1'b0;
    if (baud_tick) begin
      case (state_q)
        ST_IDLE: pick = 1'b1;
        ST_START: begin
          pin_d   = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (idx_q < len_q - 1'b1) begin
            pin_d   = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end else if (has_par_q) begin
            pin_d   = par_bit_q;
            state_d = ST_PARITY;
          end else begin
            pin_d      = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end
        end
        ST_PARITY: begin
          pin_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop2_q && !stop_cnt_q) begin
            pin_d      = 1'b1;
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            pick   = 1'b1;
          end
        end
        ST_BREAK: begin
          if (!break_req) begin
            pin_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pin_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Break outranks queued data, so a held break_req waits for the frame end.
      if (pick) begin
        if (break_req) begin
          pin_d   = 1'b0;
          state_d = ST_BREAK;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          pin_d     = 1'b0;
          state_d   = ST_START;
          shift_d   = fifo_data;
          len_d     = cfg_len;
          has_par_d = (cfg_par != PAR_NONE);
          par_bit_d = parity_bit(fifo_data, cfg_len, cfg_par);
          stop2_d   = cfg_stop2;
        end else begin
          pin_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      len_q      <= LW'(MIN_DATA_BITS);
      has_par_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      pin_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      has_par_q  <= has_par_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      pin_q      <= pin_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed and randomized bench for uart_tx_buffered against a bit-queue model
// of the serial line and a word-queue model of the FIFO.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [3:0] cfg_data_len = 4'd8;
  logic [2:0] cfg_parity = 3'd0;
  logic       cfg_stop2 = 1'b0;
  logic       break_req = 1'b0;
  logic       tx_pin, tx_busy, tx_done, fifo_empty;
  logic [2:0] fifo_level;
  tx_state_e  dbg_state;

  uart_tx_buffered_if #(.DATA_BITS(DB)) in_if ();

  always #5 clk = ~clk;

  uart_tx_buffered #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_tick    (baud_tick),
    .in_if        (in_if.slave),
    .cfg_data_len (cfg_data_len),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .break_req    (break_req),
    .tx_pin       (tx_pin),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .fifo_level   (fifo_level),
    .fifo_empty   (fifo_empty),
    .dbg_state    (dbg_state)
  );

  typedef enum {M_IDLE, M_FRAME, M_BREAK} mmode_e;

  int           checks = 0;
  int           fails = 0;
  logic [DB-1:0] host_q[$];
  logic [DB-1:0] exp_q[$];
  logic         bits_q[$];
  logic         tick_pins[$];
  int           pat_q[$];
  mmode_e       mmode = M_IDLE;
  logic         m_pin = 1'b1;
  logic         m_done = 1'b0;
  int           div = 0;
  bit           tick_en = 1'b0;
  bit           rand_valid = 1'b0;
  int           done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_parity(input logic [DB-1:0] w, input int len, input int par);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(w[i]);
    case (par)
      1:       return logic'(ones % 2);
      2:       return logic'(1 - (ones % 2));
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Frame-boundary decision: break first, then the oldest queued word.
  task automatic model_pick();
    logic [DB-1:0] w;
    int len, par;
    if (break_req) begin
      mmode = M_BREAK;
      m_pin = 1'b0;
    end else if (exp_q.size() > 0) begin
      w   = exp_q.pop_front();
      len = (cfg_data_len < 5) ? 5 : ((cfg_data_len > DB) ? DB : int'(cfg_data_len));
      par = (cfg_parity > 4) ? 0 : int'(cfg_parity);
      bits_q.delete();
      for (int i = 0; i < len; i++) bits_q.push_back(w[i]);
      if (par != 0) bits_q.push_back(model_parity(w, len, par));
      bits_q.push_back(1'b1);
      if (cfg_stop2) bits_q.push_back(1'b1);
      mmode = M_FRAME;
      m_pin = 1'b0;
    end else begin
      mmode = M_IDLE;
      m_pin = 1'b1;
    end
  endtask

  task automatic step();
    logic do_push;
    logic [DB-1:0] tmp;
    baud_tick = tick_en && (div == DIV - 1);
    div = (div + 1) % DIV;
    if (rand_valid) in_if.in_valid = (host_q.size() > 0) && ($urandom_range(0, 2) != 0);
    else            in_if.in_valid = (host_q.size() > 0);
    in_if.in_data = (host_q.size() > 0) ? host_q[0] : DB'($urandom);
    #1;
    check("in_ready", in_if.in_ready, exp_q.size() < DEPTH);
    do_push = in_if.in_valid && (exp_q.size() < DEPTH);
    m_done = 1'b0;
    if (baud_tick) begin
      case (mmode)
        M_IDLE: model_pick();
        M_FRAME: begin
          if (bits_q.size() > 0) m_pin = bits_q.pop_front();
          else begin
            m_done = 1'b1;
            model_pick();
          end
        end
        default: begin
          if (break_req) m_pin = 1'b0;
          else begin
            m_pin = 1'b1;
            mmode = M_IDLE;
          end
        end
      endcase
    end
    if (do_push) begin
      exp_q.push_back(in_if.in_data);
      tmp = host_q.pop_front();
    end
    @(posedge clk);
    @(negedge clk);
    check("tx_pin", tx_pin, m_pin);
    check("tx_done", tx_done, m_done);
    check("tx_busy", tx_busy, mmode != M_IDLE);
    check("fifo_level", fifo_level, exp_q.size());
    check("fifo_empty", fifo_empty, exp_q.size() == 0);
    if (tx_done === 1'b1) done_seen++;
    if (baud_tick && (mmode != M_IDLE || m_done)) tick_pins.push_back(tx_pin);
  endtask

  task automatic drain(input string tag, input int max_steps);
    int n = 0;
    while ((host_q.size() > 0 || exp_q.size() > 0 || mmode != M_IDLE) && n < max_steps) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, n < max_steps, 1);
  endtask

  task automatic check_pat(input string tag);
    check({tag, "_len"}, tick_pins.size(), pat_q.size());
    for (int i = 0; i < pat_q.size() && i < tick_pins.size(); i++)
      check(tag, tick_pins[i], pat_q[i]);
  endtask

  task automatic send_one(input logic [DB-1:0] w, input logic [3:0] len,
                          input logic [2:0] par, input logic s2);
    cfg_data_len = len;
    cfg_parity   = par;
    cfg_stop2    = s2;
    tick_pins.delete();
    done_seen = 0;
    host_q.push_back(w);
    drain("frame", 400);
    check("done_once", done_seen, 1);
  endtask

  initial begin
    int n;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_pin", tx_pin, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_ready", in_if.in_ready, 1);
    reset_n = 1'b1;
    tick_en = 1'b1;
    repeat (6) step();

    // 8N1 0x55, then 7E2 0x41 against the literal line patterns.
    send_one(8'h55, 4'd8, 3'd0, 1'b0);
    pat_q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    check_pat("pat_8n1");
    send_one(8'h41, 4'd7, 3'd1, 1'b1);
    pat_q = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    check_pat("pat_7e2");

    send_one(8'h00, 4'd8, 3'd2, 1'b0);
    check("odd_par", tick_pins[9], 1);
    send_one(8'hFF, 4'd8, 3'd3, 1'b0);
    check("mark_par", tick_pins[9], 1);
    send_one(8'hFF, 4'd8, 3'd4, 1'b0);
    check("space_par", tick_pins[9], 0);
    send_one(8'hA7, 4'd2, 3'd5, 1'b0);
    check("clamp_low_len", tick_pins.size(), 8);
    send_one(8'hA7, 4'd15, 3'd0, 1'b1);
    check("clamp_high_len", tick_pins.size(), 12);

    // Fill with ticks stopped, then five frames must run back to back.
    cfg_data_len = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    tick_en = 1'b0;
    for (int i = 0; i < 5; i++) host_q.push_back(DB'($urandom));
    repeat (7) step();
    check("full_level", fifo_level, 4);
    check("full_ready", in_if.in_ready, 0);
    check("fifth_waiting", host_q.size(), 1);
    tick_pins.delete();
    done_seen = 0;
    tick_en = 1'b1;
    drain("b2b", 1000);
    check("b2b_ticks", tick_pins.size(), 51);
    check("b2b_dones", done_seen, 5);

    // Break requested mid-frame with another word waiting.
    host_q.push_back(8'hC3);
    host_q.push_back(8'h5A);
    n = 0;
    while (!(mmode == M_FRAME && bits_q.size() == 4) && n < 200) begin step(); n++; end
    check("brk_reach", n < 200, 1);
    break_req = 1'b1;
    n = 0;
    while (mmode != M_BREAK && n < 200) begin step(); n++; end
    check("brk_enter", n < 200, 1);
    repeat (3 * DIV) step();
    check("brk_line", tx_pin, 0);
    break_req = 1'b0;
    drain("brk", 400);

    // Asynchronous reset in the middle of the data bits.
    host_q.push_back(8'h96);
    n = 0;
    while (!(mmode == M_FRAME && bits_q.size() == 5) && n < 200) begin step(); n++; end
    check("rst_reach", n < 200, 1);
    baud_tick = 1'b0;
    in_if.in_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_pin", tx_pin, 1);
    check("arst_level", fifo_level, 0);
    check("arst_done", tx_done, 0);
    check("arst_busy", tx_busy, 0);
    exp_q.delete(); bits_q.delete(); host_q.delete();
    mmode = M_IDLE; m_pin = 1'b1; m_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_one(8'h3C, 4'd6, 3'd1, 1'b0);

    // Random traffic with format changes and occasional breaks.
    rand_valid = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_data_len = 4'($urandom_range(0, 15));
        cfg_parity   = 3'($urandom_range(0, 7));
        cfg_stop2    = 1'($urandom_range(0, 1));
      end
      if (host_q.size() < 3 && $urandom_range(0, 5) == 0) host_q.push_back(DB'($urandom));
      if (break_req) begin
        if ($urandom_range(0, 9) == 0) break_req = 1'b0;
      end else if ($urandom_range(0, 299) == 0) break_req = 1'b1;
      step();
    end
    break_req = 1'b0;
    drain("rand", 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
